// File: rtl/dcache_bus_port.sv
`timescale 1ns/1ps
// dcache_bus_port
// Cache-side end of the coherence bus for one core. Sequences two-word
// victim writebacks and block fills for the local cache, and answers bus
// snoops by writing back dirty lines and invalidating or downgrading them.
//
// Ports
//   CLK, nRST                      clock (rising edge), async active-low reset
//   fill_req, rdx, req_addr        block fill request, exclusive flag, address
//   wb_req, wb_addr, wb_data0/1    dirty victim writeback request and words
//   fill_data0/1                   registered fill words (valid from done)
//   done, busy                     completion pulse, not-idle indicator
//   snoop_hit, snoop_dirty         cache lookup result for ccsnoopaddr
//   snoop_data0/1                  snooped line words
//   snoop_inv, snoop_clean         one-cycle line invalidate / dirty-clear
//   dREN, dWEN, daddr, dstore      bus read/write request, address, data
//   cctrans, ccwrite               coherence transaction / exclusive flags
//   dwait, dload                   bus stall and read data
//   ccwait, ccinv, ccsnoopaddr     snoop request, invalidate flag, address
module dcache_bus_port #(
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        fill_req,
  input  logic        rdx,
  input  logic        wb_req,
  input  logic [31:0] req_addr,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data0,
  input  logic [31:0] wb_data1,
  output logic [31:0] fill_data0,
  output logic [31:0] fill_data1,
  output logic        done,
  output logic        busy,
  input  logic        snoop_hit,
  input  logic        snoop_dirty,
  input  logic [31:0] snoop_data0,
  input  logic [31:0] snoop_data1,
  output logic        snoop_inv,
  output logic        snoop_clean,
  output logic        dREN,
  output logic        dWEN,
  output logic        cctrans,
  output logic        ccwrite,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] dload,
  input  logic [31:0] ccsnoopaddr
);

  // CPUID only labels the instance; it selects no logic.
  if (CPUID < 0) begin : g_cpuid_negative
  end

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, FILL0, FILL1, SNOOP, SWB0, SWB1, SEND, DONE
  } state_t;

  state_t state, state_next;
  // State to resume once a snoop has been answered (IDLE, WB0 or FILL0).
  state_t ret_state, ret_next;

  logic inv_next;
  logic clean_next;
  logic snoop_wb;

  assign snoop_wb = snoop_hit & snoop_dirty;

  // State, return register, fill capture and snoop pulse registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      fill_data0  <= '0;
      fill_data1  <= '0;
      snoop_inv   <= 1'b0;
      snoop_clean <= 1'b0;
    end else begin
      state       <= state_next;
      ret_state   <= ret_next;
      snoop_inv   <= inv_next;
      snoop_clean <= clean_next;
      if (state == FILL0 && !dwait) fill_data0 <= dload;
      if (state == FILL1 && !dwait) fill_data1 <= dload;
    end
  end

  // Next-state logic, including the return register and the pulses that
  // must be visible in the first SEND cycle.
  always_comb begin
    state_next = state;
    ret_next   = ret_state;
    inv_next   = 1'b0;
    clean_next = 1'b0;
    case (state)
      IDLE: begin
        if (ccwait) begin
          state_next = SNOOP;
          ret_next   = IDLE;
        end else if (wb_req) begin
          state_next = WB0;
        end else if (fill_req) begin
          state_next = FILL0;
        end
      end
      WB0: begin
        if (!dwait) begin
          state_next = WB1;
        end else if (ccwait) begin
          // First word not yet accepted: safe to yield the bus and replay.
          state_next = SNOOP;
          ret_next   = WB0;
        end
      end
      WB1: begin
        if (!dwait) state_next = fill_req ? FILL0 : DONE;
      end
      FILL0: begin
        if (!dwait) begin
          state_next = FILL1;
        end else if (ccwait) begin
          state_next = SNOOP;
          ret_next   = FILL0;
        end
      end
      FILL1: begin
        if (!dwait) state_next = DONE;
      end
      SNOOP: begin
        if (snoop_wb) begin
          state_next = SWB0;
        end else begin
          state_next = SEND;
          inv_next   = snoop_hit & ccinv;
        end
      end
      SWB0: begin
        if (!dwait) state_next = SWB1;
      end
      SWB1: begin
        if (!dwait) begin
          state_next = SEND;
          inv_next   = ccinv;
          clean_next = ~ccinv;
        end
      end
      SEND: begin
        // Hold here until the controller drops ccwait so the same snoop
        // cannot be taken twice.
        if (!ccwait) begin
          state_next = ret_state;
          ret_next   = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore bus outputs decoded from state.
  always_comb begin
    dREN    = 1'b0;
    dWEN    = 1'b0;
    cctrans = 1'b0;
    ccwrite = 1'b0;
    daddr   = '0;
    dstore  = '0;
    done    = 1'b0;
    busy    = (state != IDLE);
    case (state)
      WB0: begin
        dWEN   = 1'b1;
        daddr  = wb_addr;
        dstore = wb_data0;
      end
      WB1: begin
        dWEN   = 1'b1;
        daddr  = wb_addr + 32'd4;
        dstore = wb_data1;
      end
      FILL0: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = rdx;
        daddr   = req_addr;
      end
      FILL1: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = rdx;
        daddr   = req_addr + 32'd4;
      end
      SNOOP: begin
        ccwrite = snoop_wb;
      end
      SWB0: begin
        dWEN    = 1'b1;
        ccwrite = 1'b1;
        daddr   = ccsnoopaddr;
        dstore  = snoop_data0;
      end
      SWB1: begin
        dWEN    = 1'b1;
        ccwrite = 1'b1;
        daddr   = ccsnoopaddr + 32'd4;
        dstore  = snoop_data1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_bus_port.sv
`timescale 1ns/1ps
module tb_dcache_bus_port;

  logic        CLK, nRST;
  logic        fill_req, rdx, wb_req;
  logic [31:0] req_addr, wb_addr, wb_data0, wb_data1;
  logic [31:0] fill_data0, fill_data1;
  logic        done, busy;
  logic        snoop_hit, snoop_dirty;
  logic [31:0] snoop_data0, snoop_data1;
  logic        snoop_inv, snoop_clean;
  logic        dREN, dWEN, cctrans, ccwrite;
  logic [31:0] daddr, dstore;
  logic        dwait, ccwait, ccinv;
  logic [31:0] dload, ccsnoopaddr;

  dcache_bus_port #(.CPUID(0)) dut (
    .CLK(CLK), .nRST(nRST),
    .fill_req(fill_req), .rdx(rdx), .wb_req(wb_req),
    .req_addr(req_addr), .wb_addr(wb_addr),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .fill_data0(fill_data0), .fill_data1(fill_data1),
    .done(done), .busy(busy),
    .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
    .snoop_data0(snoop_data0), .snoop_data1(snoop_data1),
    .snoop_inv(snoop_inv), .snoop_clean(snoop_clean),
    .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
    .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv),
    .dload(dload), .ccsnoopaddr(ccsnoopaddr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Expected bus transfers, pushed when stimulus is issued.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ccw;
    logic        trans;
    logic        chk_trans;
  } xfer_t;
  xfer_t sb[$];

  // Bus slave: inserts wait_n stall cycles per word and answers reads.
  int          wait_n = 0;
  int          wait_cnt = 0;
  logic [31:0] cur_req = 0, cur_fd0 = 0, cur_fd1 = 0;

  initial begin
    dwait = 1'b0;
    dload = '0;
    forever begin
      @(negedge CLK);
      if (!nRST || !(dREN || dWEN)) begin
        dwait    = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt < wait_n) begin
        dwait = 1'b1;
        wait_cnt++;
      end else begin
        dwait    = 1'b0;
        wait_cnt = 0;
        dload    = (daddr == cur_req) ? cur_fd0 : cur_fd1;
        $display("xfer we=%0b addr=0x%08h store=0x%08h ccwrite=%0b cctrans=%0b",
                 dWEN, daddr, dstore, ccwrite, cctrans);
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          xfer_t e;
          e = sb.pop_front();
          check("xfer_ctl", {28'd0, dWEN, dREN, ccwrite, e.chk_trans ? cctrans : 1'b0},
                {28'd0, e.we, ~e.we, e.ccw, e.chk_trans ? e.trans : 1'b0});
          check("xfer_addr", daddr, e.addr);
          if (e.we) check("xfer_data", dstore, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        do_wb;
    logic        do_fill;
    logic        rdx;
    logic [31:0] wb_addr;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [31:0] req_addr;
    logic [31:0] fd0;
    logic [31:0] fd1;
    int          waits;
    int          exp_cyc;
  } vec_t;
  vec_t vecs[5];

  logic [31:0] last_fd0 = 0, last_fd1 = 0;

  task automatic push_fill(input logic [31:0] a, input logic r);
    sb.push_back('{1'b0, a, 32'd0, r, 1'b1, 1'b1});
    sb.push_back('{1'b0, a + 32'd4, 32'd0, r, 1'b1, 1'b1});
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctl"}, {22'd0, dREN, dWEN, cctrans, ccwrite, done, busy,
                          snoop_inv, snoop_clean, 2'd0}, 32'd0);
    check({name, "_daddr"}, daddr, 32'd0);
    check({name, "_dstore"}, dstore, 32'd0);
    check({name, "_fill"}, fill_data0 | fill_data1, 32'd0);
  endtask

  // Caller is at #1 after a rising edge with the DUT idle.
  task automatic run_req(input vec_t v);
    int cyc;
    logic got;
    wait_n  = v.waits;
    cur_req = v.req_addr;
    cur_fd0 = v.fd0;
    cur_fd1 = v.fd1;
    if (v.do_wb) begin
      sb.push_back('{1'b1, v.wb_addr, v.wd0, 1'b0, 1'b0, 1'b1});
      sb.push_back('{1'b1, v.wb_addr + 32'd4, v.wd1, 1'b0, 1'b0, 1'b1});
    end
    if (v.do_fill) push_fill(v.req_addr, v.rdx);
    wb_req = v.do_wb; fill_req = v.do_fill; rdx = v.rdx;
    wb_addr = v.wb_addr; wb_data0 = v.wd0; wb_data1 = v.wd1;
    req_addr = v.req_addr;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge CLK); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("done_cycle", cyc, v.exp_cyc);
    if (v.do_fill) begin
      last_fd0 = v.fd0;
      last_fd1 = v.fd1;
    end
    check("fill_data0", fill_data0, last_fd0);
    check("fill_data1", fill_data1, last_fd1);
    wb_req = 1'b0; fill_req = 1'b0;
    @(posedge CLK); #1;
    check("after_done", {30'd0, done, busy}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  // Snoop from IDLE; ccwait is held for 'hold' cycles after SNOOP.
  task automatic snoop_seq(input logic hit, input logic dirty, input logic inv,
                           input logic [31:0] a, input logic [31:0] d0,
                           input logic [31:0] d1, input int waits, input int hold,
                           input int exp_inv, input int exp_clean);
    int n_inv, n_clean;
    wait_n = waits;
    if (hit && dirty) begin
      sb.push_back('{1'b1, a, d0, 1'b1, 1'b0, 1'b0});
      sb.push_back('{1'b1, a + 32'd4, d1, 1'b1, 1'b0, 1'b0});
    end
    snoop_hit = hit; snoop_dirty = dirty; ccinv = inv;
    ccsnoopaddr = a; snoop_data0 = d0; snoop_data1 = d1;
    ccwait = 1'b1;
    @(posedge CLK); #1;
    check("snoop_ccwrite", {31'd0, ccwrite}, {31'd0, hit & dirty});
    check("snoop_bus_idle", {29'd0, dREN, dWEN, cctrans}, 32'd0);
    n_inv = 0; n_clean = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      n_inv += int'(snoop_inv);
      n_clean += int'(snoop_clean);
    end
    check("snoop_busy_held", {31'd0, busy}, 32'd1);
    ccwait = 1'b0;
    @(posedge CLK); #1;
    n_inv += int'(snoop_inv);
    n_clean += int'(snoop_clean);
    check("snoop_return_idle", {31'd0, busy}, 32'd0);
    check("snoop_inv_count", n_inv, exp_inv);
    check("snoop_clean_count", n_clean, exp_clean);
    check("snoop_sb_drained", sb.size(), 32'd0);
    snoop_hit = 1'b0; snoop_dirty = 1'b0; ccinv = 1'b0;
  endtask

  task automatic preempt_seq();
    int cyc;
    logic got;
    wait_n = 4; cur_req = 32'h600; cur_fd0 = 32'h6A; cur_fd1 = 32'h6B;
    push_fill(32'h600, 1'b0);
    req_addr = 32'h600; rdx = 1'b0; fill_req = 1'b1;
    @(posedge CLK); #1;
    check("pre_fill0_dren", {31'd0, dREN}, 32'd1);
    @(posedge CLK); #1;
    snoop_hit = 1'b0; snoop_dirty = 1'b0; ccinv = 1'b1;
    ccsnoopaddr = 32'h900; ccwait = 1'b1;
    @(posedge CLK); #1;
    check("preempt_bus_drop", {30'd0, dREN, dWEN}, 32'd0);
    check("preempt_busy", {31'd0, busy}, 32'd1);
    @(posedge CLK); #1;
    ccwait = 1'b0;
    @(posedge CLK); #1;
    check("resume_dren", {31'd0, dREN}, 32'd1);
    check("resume_daddr", daddr, 32'h600);
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge CLK); #1;
      if (done) got = 1'b1;
      if (snoop_inv || snoop_clean) cyc++;
    end
    check("preempt_done_seen", {31'd0, got}, 32'd1);
    check("preempt_no_pulse", cyc, 32'd0);
    last_fd0 = 32'h6A; last_fd1 = 32'h6B;
    check("preempt_fill0", fill_data0, 32'h6A);
    check("preempt_fill1", fill_data1, 32'h6B);
    fill_req = 1'b0; ccinv = 1'b0;
    @(posedge CLK); #1;
    check("preempt_sb_drained", sb.size(), 32'd0);
  endtask

  task automatic reset_in_swb1();
    logic found;
    wait_n = 2;
    sb.push_back('{1'b1, 32'h400, 32'hC0, 1'b1, 1'b0, 1'b0});
    sb.push_back('{1'b1, 32'h404, 32'hC1, 1'b1, 1'b0, 1'b0});
    snoop_hit = 1'b1; snoop_dirty = 1'b1; ccinv = 1'b1;
    ccsnoopaddr = 32'h400; snoop_data0 = 32'hC0; snoop_data1 = 32'hC1;
    ccwait = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge CLK); #1;
      if (dWEN && daddr == 32'h404) found = 1'b1;
    end
    check("found_swb1", {31'd0, found}, 32'd1);
    nRST = 1'b0;
    #1;
    check_quiet("rst_swb1");
    sb.delete();
    ccwait = 1'b0; snoop_hit = 1'b0; snoop_dirty = 1'b0; ccinv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      check("rst_hold_quiet", {29'd0, busy, snoop_inv, snoop_clean}, 32'd0);
    end
    nRST = 1'b1;
    last_fd0 = 32'd0; last_fd1 = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("post_rst_idle", {29'd0, busy, snoop_inv, snoop_clean}, 32'd0);
    end
  endtask

  initial begin
    nRST = 1'b0;
    fill_req = 0; rdx = 0; wb_req = 0;
    req_addr = 0; wb_addr = 0; wb_data0 = 0; wb_data1 = 0;
    snoop_hit = 0; snoop_dirty = 0; snoop_data0 = 0; snoop_data1 = 0;
    ccwait = 0; ccinv = 0; ccsnoopaddr = 0;

    //          wb    fill  rdx   wb_addr        wd0     wd1     req_addr  fd0       fd1      w  cyc
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,  32'h0,  32'h100, 32'hAAAA, 32'hBBBB, 0, 3};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h200,       32'h11, 32'h22, 32'h300, 32'h33,   32'h44,   2, 13};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h500,       32'h55, 32'h66, 32'h0,   32'h0,    32'h0,    1, 5};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h77, 32'h88, 32'h700, 32'h99,   32'hAB,   0, 5};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0,  32'h0,  32'h800, 32'hCD,   32'hEF,   3, 9};

    @(posedge CLK); @(posedge CLK); #1;
    check_quiet("reset");
    nRST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 5; i++) run_req(vecs[i]);

    // Dirty hit with invalidate, clean hit without / with invalidate,
    // dirty hit downgrade, and a minimum-length miss.
    snoop_seq(1'b1, 1'b1, 1'b1, 32'h400, 32'hD0, 32'hD1, 1, 12, 1, 0);
    snoop_seq(1'b1, 1'b0, 1'b0, 32'h410, 32'h0,  32'h0,  0, 3,  0, 0);
    snoop_seq(1'b1, 1'b0, 1'b1, 32'h420, 32'h0,  32'h0,  0, 3,  1, 0);
    snoop_seq(1'b1, 1'b1, 1'b0, 32'h430, 32'hE0, 32'hE1, 0, 6,  0, 1);
    snoop_seq(1'b0, 1'b0, 1'b1, 32'h440, 32'h0,  32'h0,  0, 1,  0, 0);

    preempt_seq();
    reset_in_swb1();
    run_req(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
